// File: rtl/tt_sweep_checker.sv
// Truth-table sweep checker: walks a 4-input circuit through all 16 rows,
// samples its output twice per row and compares the table against EXPECTED.
module tt_sweep_checker #(
   parameter logic [15:0] EXPECTED = 16'h4BF8,
   parameter int unsigned SETTLE   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        dut_out,
   output logic        drv_in1,
   output logic        drv_in2,
   output logic        drv_in3,
   output logic        drv_in4,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] captured,
   output logic [15:0] mismatch,
   output logic [15:0] unstable
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] HOLD   = 3'd1;
   localparam logic [2:0] SAMP_A = 3'd2;
   localparam logic [2:0] SAMP_B = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

   logic [2:0]  state_q,    state_d;
   logic [3:0]  k_q,        k_d;
   logic [7:0]  cnt_q,      cnt_d;
   logic        a_q,        a_d;
   logic [3:0]  drv_q,      drv_d;
   logic        busy_q,     busy_d;
   logic        done_q,     done_d;
   logic        pass_q,     pass_d;
   logic [15:0] captured_q, captured_d;
   logic [15:0] mismatch_q, mismatch_d;
   logic [15:0] unstable_q, unstable_d;

   // Row k lands in bit (15-k), i.e. bit index ~k, so row 0 is the table MSB.
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      drv_d      = drv_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      captured_d = captured_q;
      mismatch_d = mismatch_q;
      unstable_d = unstable_q;

      case (state_q)
         IDLE, DONE: begin
            if (start && !abort) begin
               state_d    = HOLD;
               k_d        = 4'd0;
               cnt_d      = SETTLE_LOAD;
               drv_d      = 4'd0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               captured_d = 16'h0000;
               unstable_d = 16'h0000;
            end
         end

         HOLD, SAMP_A, SAMP_B: begin
            if (abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               drv_d   = 4'd0;
            end else begin
               case (state_q)
                  HOLD: begin
                     if (cnt_q == 8'd0) begin
                        state_d = SAMP_A;
                     end else begin
                        cnt_d = cnt_q - 8'd1;
                     end
                  end
                  SAMP_A: begin
                     a_d     = dut_out;
                     state_d = SAMP_B;
                  end
                  default: begin
                     captured_d[~k_q] = a_q;
                     unstable_d[~k_q] = a_q ^ dut_out;
                     if (k_q != 4'd15) begin
                        k_d     = k_q + 4'd1;
                        drv_d   = k_q + 4'd1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = HOLD;
                     end else begin
                        // Verdict uses the next-state table so row 15 is included.
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        drv_d      = 4'd0;
                        mismatch_d = captured_d ^ EXPECTED;
                        pass_d     = (captured_d == EXPECTED) && (unstable_d == 16'h0000);
                     end
                  end
               endcase
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            drv_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         k_q        <= 4'd0;
         cnt_q      <= 8'd0;
         a_q        <= 1'b0;
         drv_q      <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         captured_q <= 16'h0000;
         mismatch_q <= 16'h0000;
         unstable_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         drv_q      <= drv_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         captured_q <= captured_d;
         mismatch_q <= mismatch_d;
         unstable_q <= unstable_d;
      end
   end

   assign drv_in1  = drv_q[3];
   assign drv_in2  = drv_q[2];
   assign drv_in3  = drv_q[1];
   assign drv_in4  = drv_q[0];
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign captured = captured_q;
   assign mismatch = mismatch_q;
   assign unstable = unstable_q;

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational logic netlist (gate-level NOT/NOR circuit, e.g. truth table 0x4BF8). It drives all 16 input combinations onto the circuit's in1..in4, waits a settle window and samples the circuit's single output twice per vector. It then assembles the measured 16-bit truth table and compares it against an expected hex value. Used in bench and FPGA bring-up to confirm that every synthesized Cello design matches its truth-table name.

Parameters:
EXPECTED, 16'h4BF8, expected truth table, MSB = input row 0.
SETTLE, 4, cycles each vector is held before the first sample (legal range 1..255).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep in progress
dut_out  input  1  output of the circuit under test
drv_in1  output  1  drives circuit in1 (row index bit 3)
drv_in2  output  1  drives circuit in2 (row index bit 2)
drv_in3  output  1  drives circuit in3 (row index bit 1)
drv_in4  output  1  drives circuit in4 (row index bit 0)
busy  output  1  sweep in progress
done  output  1  results valid, held until next accepted start
pass  output  1  captured == EXPECTED and unstable == 0; valid when done
captured  output  16  measured table, bit (15-k) = output for row k
mismatch  output  16  captured XOR EXPECTED
unstable  output  16  bit (15-k) set if the two samples of row k differed

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset: state IDLE. busy, done and pass are 0. drv_in1..4 are 0. captured, mismatch and unstable are 0. Reset asserted mid-sweep takes effect on the next edge with the same values.
- FSM states: IDLE, HOLD, SAMP_A, SAMP_B, DONE.
- IDLE, start=1: row k=0 is latched, drivers are set to k, busy=1, done=0, and captured/unstable are cleared. Go to HOLD with counter=SETTLE-1.
- HOLD: counter decrements each cycle. At 0, go to SAMP_A. Drivers are held stable.
- SAMP_A: register dut_out as sample a. Go to SAMP_B.
- SAMP_B:
  - captured[15-k] <= a.
  - unstable[15-k] <= a XOR dut_out.
  - If k<15: k <= k+1, drivers update on the same edge, go to HOLD with counter=SETTLE-1.
  - If k=15: go to DONE.
- Vector timing: each row is driven for exactly SETTLE+2 cycles. A full sweep takes 16*(SETTLE+2) cycles from the start edge to the DONE entry edge.
- DONE:
  - busy=0, done=1.
  - mismatch = captured XOR EXPECTED.
  - pass = (mismatch==0) && (unstable==0).
  - Drivers return to 0.
  - Results hold until the next start. start=1 in DONE behaves as in IDLE: clears done and begins a new sweep.
- Output registration: all outputs are registered. mismatch and pass update on the DONE entry edge only.
- start while busy: ignored.
- abort=1 while busy: next state IDLE, busy=0, done=0, drivers 0; captured and unstable keep partial contents. abort outside busy has no effect. abort together with start in IDLE: abort wins, no sweep starts.
- Row counter k is 4 bits and does not wrap during a sweep; the k=15 test terminates it.

Test Plan:
- Correct circuit: connect a gate-level 0x4BF8 model, SETTLE=4, pulse start. Expect done exactly 96 cycles after the start edge, captured=16'h4BF8, mismatch=0, unstable=0, pass=1.
- Stuck-at-0 circuit: tie dut_out=0. Expect captured=16'h0000, mismatch=16'h4BF8, pass=0.
- Row-order check: dut_out=drv_in4 (function = in4). Expect captured=16'h5555. With dut_out=drv_in1, expect captured=16'h00FF.
- Glitch: toggle dut_out between SAMP_A and SAMP_B on row 5 only, otherwise 0x4BF8 model. Expect unstable=16'h0400 and pass=0.
- Abort and restart: abort at cycle 30 of a sweep. Expect busy=0 and done=0 next cycle, drivers=0. A new start then completes with pass=1.
- Reset and ignored start: assert rst mid-sweep, then expect all outputs 0 next cycle. A start pulse during busy does not lengthen the sweep beyond 16*(SETTLE+2) cycles.
